uart_tx_controller: RTL
=======================

Name: uart_tx_controller

Overview:
- Sequences the UART transmit path: accepts a parallel byte, then drives the start bit, data bits (LSB first), optional parity bit and stop bit(s) onto the serial line. Each bit lasts one BIT_TICK period.
- Sits between the host-side parallel interface and the TX pin.
- BIT_TICK comes from the shared baud/tick generator. TICK_CLR re-phases that generator at the start of each frame.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (5..8).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- P_DATA  input  DATA_WIDTH  parallel byte to send.
- Data_Valid  input  1  one-cycle request to send P_DATA.
- PAR_EN  input  1  parity bit enable; sampled at frame accept.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled at frame accept.
- BIT_TICK  input  1  one-cycle pulse marking the end of a bit period.
- TICK_CLR  output  1  one-cycle pulse that restarts the tick generator phase.
- TX_OUT  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse when the last stop bit ends.

Behaviour:
- Interface decision: one clock, clk. Reset rst is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values:
  - state = IDLE, TX_OUT = 1, busy = 0, frame_done = 0, TICK_CLR = 0.
  - Bit counter = 0, holding register = 0.
- Reset mid-frame: TX_OUT returns to 1 on the next cycle. The frame is abandoned and no frame_done is issued.
- States: IDLE, START, DATA, PARITY, STOP.
- busy = (state != IDLE), decoded from registered state.
- TX_OUT is registered: 1 in IDLE and STOP, 0 in START, current data bit in DATA, parity bit in PARITY.
- IDLE:
  - Data_Valid = 1 latches P_DATA, PAR_EN and PAR_TYP into registers, and pulses TICK_CLR in that same cycle.
  - Next state is START; TX_OUT goes low the following cycle.
  - Latency from Data_Valid to the falling TX_OUT edge is 1 cycle.
- START: on BIT_TICK go to DATA with bit index = 0.
- DATA:
  - TX_OUT = held[index].
  - On BIT_TICK: if index == DATA_WIDTH-1, go to PARITY when the latched PAR_EN = 1, otherwise to STOP. Else increment index.
- PARITY:
  - Parity bit = XOR of the DATA_WIDTH held bits, XOR the latched PAR_TYP.
  - On BIT_TICK go to STOP.
- STOP:
  - Counts STOP_BITS ticks.
  - On the final tick: pulse frame_done and go to IDLE.
- Data_Valid while busy is ignored (without the optional feature). This includes the cycle in which the final stop tick arrives.
- Changes to P_DATA, PAR_EN or PAR_TYP after frame accept have no effect on the frame in progress.
- BIT_TICK in IDLE is ignored.
- Back-to-back frames give a minimum of one idle (high) cycle plus TICK_CLR between frames.
- Counter widths: index is $clog2(DATA_WIDTH) bits. The stop counter is 1 bit; it never wraps beyond its terminal value.

Optional Feature:
- Macro: UART_TX_PENDING_BUF_EN.
- Defined:
  - Adds a one-entry pending buffer (data, PAR_EN, PAR_TYP plus a valid flag).
  - Data_Valid while busy and the buffer is empty fills the buffer. Data_Valid while the buffer is full is dropped.
  - On the final stop tick with the buffer valid: go directly to START, pulse TICK_CLR, transfer the buffer to the holding register, suppress the IDLE cycle, and still pulse frame_done.
  - Data_Valid in the same cycle as the final stop tick is accepted into the buffer, or, if the buffer is already full, dropped.
  - busy stays high across chained frames.
- Undefined: no buffer; Data_Valid while busy is ignored as described above.

Test Plan:
- Reset, then Data_Valid with P_DATA = 8'hA5, PAR_EN = 0, BIT_TICK every 16 cycles:
  - Required TX_OUT sequence: 0, 1,0,1,0,0,1,0,1, 1.
  - TICK_CLR pulses in the accept cycle; frame_done pulses once; busy is high for 10 bit periods.
- P_DATA = 8'h03, PAR_EN = 1, PAR_TYP = 0 -> parity bit = 0. Repeat with PAR_TYP = 1 -> parity bit = 1. Frame is 11 bits.
- STOP_BITS = 2, P_DATA = 8'hFF -> two stop periods high before frame_done.
- Second Data_Valid (8'h55) issued mid-frame:
  - Without macro: ignored, line stays high after the first frame.
  - With macro: 8'h55 is sent immediately after the stop bit with no idle cycle, and frame_done pulses twice.
- Assert rst during DATA bit 4 -> next cycle TX_OUT = 1, busy = 0, no frame_done; a following Data_Valid sends a clean frame.
- Change P_DATA and PAR_EN one cycle after accept -> the transmitted frame matches the originally latched values.

Source files
------------

// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Define UART_TX_PENDING_BUF_EN to add a one-entry pending buffer for chained frames.
module uart_tx_controller #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  BIT_TICK,
  output logic                  TICK_CLR,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);
  localparam logic StopLast = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] held_q, held_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  stop_q, stop_d;
  logic                  tx_q, tx_d;

`ifdef UART_TX_PENDING_BUF_EN
  logic                  buf_vld_q, buf_vld_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic                  buf_par_en_q, buf_par_en_d;
  logic                  buf_par_typ_q, buf_par_typ_d;
`endif

  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    idx_d      = idx_q;
    stop_d     = stop_q;
    TICK_CLR   = 1'b0;
    frame_done = 1'b0;
`ifdef UART_TX_PENDING_BUF_EN
    buf_vld_d     = buf_vld_q;
    buf_data_d    = buf_data_q;
    buf_par_en_d  = buf_par_en_q;
    buf_par_typ_d = buf_par_typ_q;
`endif

    case (state_q)
      StIdle: begin
`ifdef UART_TX_PENDING_BUF_EN
        if (buf_vld_q) begin
          held_d    = buf_data_q;
          par_en_d  = buf_par_en_q;
          par_typ_d = buf_par_typ_q;
          buf_vld_d = 1'b0;
          TICK_CLR  = 1'b1;
          state_d   = StStart;
          if (Data_Valid) begin
            buf_data_d    = P_DATA;
            buf_par_en_d  = PAR_EN;
            buf_par_typ_d = PAR_TYP;
            buf_vld_d     = 1'b1;
          end
        end else
`endif
        if (Data_Valid) begin
          held_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          TICK_CLR  = 1'b1;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (BIT_TICK) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (BIT_TICK) begin
          if (idx_q == IdxLast) begin
            state_d = par_en_q ? StParity : StStop;
            stop_d  = 1'b0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (BIT_TICK) begin
          state_d = StStop;
          stop_d  = 1'b0;
        end
      end
      StStop: begin
        if (BIT_TICK) begin
          if (stop_q == StopLast) begin
            frame_done = 1'b1;
            state_d    = StIdle;
`ifdef UART_TX_PENDING_BUF_EN
            // Chain straight into the buffered frame, skipping the idle cycle.
            if (buf_vld_q) begin
              held_d    = buf_data_q;
              par_en_d  = buf_par_en_q;
              par_typ_d = buf_par_typ_q;
              buf_vld_d = 1'b0;
              TICK_CLR  = 1'b1;
              state_d   = StStart;
            end
`endif
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef UART_TX_PENDING_BUF_EN
    // A full buffer at the final stop tick is being drained, so the request is dropped.
    if (Data_Valid && (state_q != StIdle) && !buf_vld_q) begin
      buf_data_d    = P_DATA;
      buf_par_en_d  = PAR_EN;
      buf_par_typ_d = PAR_TYP;
      buf_vld_d     = 1'b1;
    end
`endif

    if (rst) begin
      TICK_CLR   = 1'b0;
      frame_done = 1'b0;
    end

    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = held_d[idx_d];
      StParity: tx_d = (^held_d) ^ par_typ_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      held_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PENDING_BUF_EN
      buf_vld_q     <= 1'b0;
      buf_data_q    <= '0;
      buf_par_en_q  <= 1'b0;
      buf_par_typ_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      idx_q     <= idx_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PENDING_BUF_EN
      buf_vld_q     <= buf_vld_d;
      buf_data_q    <= buf_data_d;
      buf_par_en_q  <= buf_par_en_d;
      buf_par_typ_q <= buf_par_typ_d;
`endif
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = (state_q != StIdle);

endmodule
